layer_compositor: RTL
=====================

# layer_compositor

Parametrised, pipelined VGA pixel compositor; successor to the fixed three-sprite color mapper. It resolves NUM_LAYERS prioritised sprite/background layers through runtime-writable per-layer palettes with colour-key transparency and emits registered VGA RGB. It sits between the sprite/background ROM address logic and the VGA output pins, clocked on the pixel clock.

## Interface
- NUM_LAYERS, 4, layer count; layer 0 has the highest priority and layer NUM_LAYERS-1 is the background.
- IDX_W, 3, palette index width; palette depth = 2**IDX_W.
- KEY_COLOR, 24'hFFFFFF, transparent colour key for layers 0..NUM_LAYERS-2.
- FILL_COLOR, 24'h00FF00, colour output when no layer resolves.
- FADE_STEP, 16, fade level change per frame tick (FADE build only).

- Clk  in  1  pixel clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid_in  in  1  pixel qualifier for the same-cycle inputs.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- layer_hit  in  NUM_LAYERS  bit i set = pixel lies inside layer i.
- layer_idx  in  NUM_LAYERS*IDX_W  palette index for layer i at bits [i*IDX_W +: IDX_W].
- pal_we  in  1  palette write strobe.
- pal_layer  in  $clog2(NUM_LAYERS)  palette to write.
- pal_addr  in  IDX_W  entry to write.
- pal_wdata  in  24  RGB 8:8:8 entry value.
- frame_tick  in  1  one-cycle pulse at start of frame (FADE build only).
- fade_go  in  1  one-cycle fade request (FADE build only).
- fade_busy  out  1  fade engine not IDLE (FADE build only).
- pix_valid_out  out  1  delayed pix_valid_in.
- DrawX_out, DrawY_out  out  10 each  coordinates aligned with the RGB output.
- VGA_R, VGA_G, VGA_B  out  8 each  output colour.

## Operation
- The block holds one palette per layer, each 2**IDX_W x 24-bit registers. All palette entries reset to 24'h000000.
- A write with pal_we=1 updates palette[pal_layer][pal_addr] at the clock edge. A pal_layer value >= NUM_LAYERS is ignored.
- Stage 1 (S1): each layer's colour is looked up from palette[i][layer_idx_i] and registered together with layer_hit, pix_valid_in, DrawX and DrawY.
- Stage 2 (S2) selects the lowest i with hit_i=1 and colour_i != KEY_COLOR, scanning i < NUM_LAYERS-1. The background layer (NUM_LAYERS-1) ignores the key: if it is hit, its colour is used as-is. If nothing resolves, FILL_COLOR is used. The result is registered to the VGA outputs.
- When pix_valid is 0 in S2, the VGA outputs are forced to 0. This provides blanking.
- Read/write collision: an S1 lookup in the same cycle as a write to the same entry returns the old value. The new value is visible from the next cycle.

## Timing
- Latency is 2 cycles (3 with FADE) from inputs to VGA_*, pix_valid_out and Draw*_out. All three stay mutually aligned. Throughput is one pixel per clock with no stalls.
- Reset (asynchronous assert, any time, including mid-frame or mid-fade):
  - All pipeline registers clear, so VGA_* = 0, pix_valid_out = 0 and Draw*_out = 0.
  - Palettes clear to 0.
  - The fade FSM goes to IDLE with level = 256, so fade_busy = 0.
- Reset deassertion is synchronised externally. The first valid output appears 2 (or 3) cycles after the first pix_valid_in.

## Configuration
- Macro: COMPOSITOR_FADE_EN.
- **Defined:** adds a fade engine and a stage 3.
  - Level is a 9-bit value in 0..256. FSM states:
    - IDLE (level 256): fade_go -> DOWN.
    - DOWN: each frame_tick, level -= FADE_STEP, saturating at 0; level 0 -> HOLD.
    - HOLD: fade_go -> UP.
    - UP: each frame_tick, level += FADE_STEP, saturating at 256; level 256 -> IDLE.
  - fade_go is ignored in DOWN and UP.
  - If fade_go and frame_tick arrive in the same cycle in IDLE, the transition happens first. The first decrement occurs on the next frame_tick.
  - Stage 3 computes each channel as (c*level)>>8, using a 17-bit product.
  - Level is sampled once per pixel in stage 3.
- **Undefined:** no fade logic and 2-cycle latency. frame_tick and fade_go are absent, and fade_busy is absent.

## Test plan
- **Reset:** assert Reset_n=0 mid-stream -> VGA_*=0 and pix_valid_out=0 immediately (asynchronously); palette reads return 0 after release.
- **Priority:**
  - Setup: write pal0[2]=24'hA2272C and pal3[1]=24'h297BA2; hit=4'b1001, idx0=2, idx3=1.
  - Required: RGB A2/27/2C after 2 cycles.
  - Then set idx0 to an entry holding FFFFFF -> RGB 29/7B/A2.
- **Fill:** hit=4'b0000 with pix_valid_in=1 -> RGB 00/FF/00. The same with pix_valid_in=0 -> 00/00/00.
- **Collision:** write pal1[5]=24'h123456 in the same cycle as a lookup of pal1[5] (old value 0) -> output 000000, then 123456 on the next pixel.
- **Fade** (COMPOSITOR_FADE_EN, FADE_STEP=128):
  - fade_go, then 2 frame_ticks -> level 128, then 0; pixel FF8040 outputs 7F4020, then 000000; fade_busy=1.
  - fade_go in HOLD, then 2 ticks -> FF8040 and IDLE.
- **Alignment:** sweep DrawX 0..639 with random hits -> Draw*_out equals the input delayed by the configured latency on every cycle.

Source files
------------

// File: rtl/layer_compositor.sv
// Pipelined VGA layer compositor: per-layer palettes, colour-key priority
// resolve, blanking; optional frame fade engine (COMPOSITOR_FADE_EN).
// Ports:
//   Clk, Reset_n                     pixel clock, async active-low reset.
//   pix_valid_in, DrawX, DrawY       pixel qualifier and coordinates.
//   layer_hit, layer_idx             per-layer hit flag and palette index.
//   pal_we, pal_layer, pal_addr,
//   pal_wdata                        palette write port.
//   frame_tick, fade_go, fade_busy   fade control/status (fade build only).
//   pix_valid_out, DrawX_out,
//   DrawY_out                        qualifier/coordinates aligned with RGB.
//   VGA_R, VGA_G, VGA_B              registered output colour.
module layer_compositor #(
  parameter int          NUM_LAYERS = 4,
  parameter int          IDX_W      = 3,
  parameter logic [23:0] KEY_COLOR  = 24'hFFFFFF,
  parameter logic [23:0] FILL_COLOR = 24'h00FF00
`ifdef COMPOSITOR_FADE_EN
  ,
  parameter int          FADE_STEP  = 16
`endif
) (
  input  logic                                Clk,
  input  logic                                Reset_n,
  input  logic                                pix_valid_in,
  input  logic [9:0]                          DrawX,
  input  logic [9:0]                          DrawY,
  input  logic [NUM_LAYERS-1:0]               layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0]         layer_idx,
  input  logic                                pal_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]       pal_layer,
  input  logic [IDX_W-1:0]                    pal_addr,
  input  logic [23:0]                         pal_wdata,
`ifdef COMPOSITOR_FADE_EN
  input  logic                                frame_tick,
  input  logic                                fade_go,
  output logic                                fade_busy,
`endif
  output logic                                pix_valid_out,
  output logic [9:0]                          DrawX_out,
  output logic [9:0]                          DrawY_out,
  output logic [7:0]                          VGA_R,
  output logic [7:0]                          VGA_G,
  output logic [7:0]                          VGA_B
);

  localparam int DEPTH = 1 << IDX_W;

  logic [23:0] pal [NUM_LAYERS][DEPTH];

  // Reads in S1 see the pre-write value on a same-entry collision.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int l = 0; l < NUM_LAYERS; l++)
        for (int e = 0; e < DEPTH; e++)
          pal[l][e] <= '0;
    end else if (pal_we && int'(pal_layer) < NUM_LAYERS) begin
      pal[pal_layer][pal_addr] <= pal_wdata;
    end
  end

  // S1: palette lookup
  logic [23:0]           col1 [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] hit1;
  logic                  v1;
  logic [9:0]            x1, y1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++)
        col1[i] <= '0;
      hit1 <= '0;
      v1   <= 1'b0;
      x1   <= '0;
      y1   <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++)
        col1[i] <= pal[i][layer_idx[i*IDX_W +: IDX_W]];
      hit1 <= layer_hit;
      v1   <= pix_valid_in;
      x1   <= DrawX;
      y1   <= DrawY;
    end
  end

  // S2: priority resolve; background layer bypasses the key
  logic [23:0] sel_col;
  logic        sel_found;

  always_comb begin
    sel_col   = FILL_COLOR;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_LAYERS - 1; i++) begin
      if (!sel_found && hit1[i] && col1[i] != KEY_COLOR) begin
        sel_col   = col1[i];
        sel_found = 1'b1;
      end
    end
    if (!sel_found && hit1[NUM_LAYERS-1])
      sel_col = col1[NUM_LAYERS-1];
    if (!v1)
      sel_col = '0;
  end

  logic [23:0] rgb2;
  logic        v2;
  logic [9:0]  x2, y2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb2 <= '0;
      v2   <= 1'b0;
      x2   <= '0;
      y2   <= '0;
    end else begin
      rgb2 <= sel_col;
      v2   <= v1;
      x2   <= x1;
      y2   <= y1;
    end
  end

`ifdef COMPOSITOR_FADE_EN
  typedef enum logic [1:0] {IDLE, DOWN, HOLD, UP} fade_t;

  localparam logic [8:0] STEP = 9'(FADE_STEP);
  localparam logic [8:0] FULL = 9'd256;

  fade_t      state, state_n;
  logic [8:0] level, level_n;
  logic [9:0] up_sum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      level <= FULL;
    end else begin
      state <= state_n;
      level <= level_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    up_sum  = {1'b0, level} + {1'b0, STEP};
    unique case (state)
      IDLE: if (fade_go) state_n = DOWN;
      DOWN: if (frame_tick) begin
        level_n = (level > STEP) ? level - STEP : 9'd0;
        if (level_n == 9'd0) state_n = HOLD;
      end
      HOLD: if (fade_go) state_n = UP;
      UP: if (frame_tick) begin
        level_n = (up_sum >= 10'd256) ? FULL : up_sum[8:0];
        if (level_n == FULL) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign fade_busy = (state != IDLE);

  // S3: scale by level/256; level 256 passes colour unchanged
  logic [16:0] pr, pg, pb;
  assign pr = 17'(rgb2[23:16]) * 17'(level);
  assign pg = 17'(rgb2[15:8])  * 17'(level);
  assign pb = 17'(rgb2[7:0])   * 17'(level);

  logic [23:0] rgb3;
  logic        v3;
  logic [9:0]  x3, y3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb3 <= '0;
      v3   <= 1'b0;
      x3   <= '0;
      y3   <= '0;
    end else begin
      rgb3 <= {8'(pr >> 8), 8'(pg >> 8), 8'(pb >> 8)};
      v3   <= v2;
      x3   <= x2;
      y3   <= y2;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb3;
  assign pix_valid_out = v3;
  assign DrawX_out     = x3;
  assign DrawY_out     = y3;
`else
  assign {VGA_R, VGA_G, VGA_B} = rgb2;
  assign pix_valid_out = v2;
  assign DrawX_out     = x2;
  assign DrawY_out     = y2;
`endif

endmodule
